imm_gen_pipe: RTL

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit RISC-V instruction and an immediate-type select, then produces the sign-extended immediate at XLEN width through a registered valid/ready stage with a 2-entry skid buffer. It sits between fetch/decode and the register-read/execute boundary and carries a sideband tag alongside each immediate. Unsupported selects are flagged as illegal rather than producing X.

---
 rtl/imm_gen_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready bundle carrying instruction+select in and immediate+tag out
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_ctrl;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_ctrl, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_ctrl, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decode behind a registered stage with a skid entry; IMM_GEN_ZIMM_EN enables select 101 (CSR zimm)
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    imm_gen_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic             out_ill_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [XLEN-1:0]  skid_imm;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;
    logic [31:0]      dec32;
    logic             dec_ill;
    logic [XLEN-1:0]  dec_imm;
    logic             acc;
    logic             drn;
    logic             unused_ok;

    assign acc       = bus.in_valid && in_ready_q;
    assign drn       = out_valid_q && bus.out_ready;
    assign unused_ok = ^bus.in_instr[6:0];

    // Decode every form to 32 bits; zimm has bit 31 clear so one sign-extension serves all
    always_comb begin
        dec32   = '0;
        dec_ill = 1'b0;
        case (bus.in_ctrl)
            3'b000: dec32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            3'b001: dec32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            3'b010: dec32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                             bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            3'b011: dec32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                             bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            3'b100: dec32 = {bus.in_instr[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
            3'b101: dec32 = {27'b0, bus.in_instr[19:15]};
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec32));

    // Stage control: output register plus one skid entry, strict FIFO, flush/reset empty it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_ill_q   <= 1'b0;
            out_tag_q   <= '0;
            skid_imm    <= '0;
            skid_ill    <= 1'b0;
            skid_tag    <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        out_imm_q   <= dec_imm;
                        out_ill_q   <= dec_ill;
                        out_tag_q   <= bus.in_tag;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        out_imm_q <= dec_imm;
                        out_ill_q <= dec_ill;
                        out_tag_q <= bus.in_tag;
                    end else if (acc) begin
                        skid_imm   <= dec_imm;
                        skid_ill   <= dec_ill;
                        skid_tag   <= bus.in_tag;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (drn) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (drn) begin
                        out_imm_q  <= skid_imm;
                        out_ill_q  <= skid_ill;
                        out_tag_q  <= skid_tag;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_illegal = out_ill_q;
    assign bus.out_tag     = out_tag_q;
endmodule
